distance_filter: RTL and testbench

Downstream consumer of the echo chronometer in the ultrasonic ranging path. On each completed echo measurement (falling edge of `busy`), it validates the recorded echo time in µs and converts it to centimetres with a serial divider. It averages the last 4 valid samples and drives a hysteretic `near` flag. This block replaces the single-sample combinational LED compare.

---
 rtl/ultrasonic_pkg.sv | 7 +
 rtl/serial_divider.sv | 41 ++++
 rtl/distance_filter.sv | 119 +++++++++++
 tb/tb_distance_filter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
// ultrasonic_pkg: shared constants and filter FSM encoding for the ultrasonic ranging path
package ultrasonic_pkg;
  localparam int US_PER_CM = 58;
  localparam int NEAR_CM = 50;
  localparam int HYST_CM = 5;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIVIDE, S_ACCUM, S_OUTPUT} state_t;
endpackage

// File: rtl/serial_divider.sv
// serial_divider: restoring divider by a constant, one quotient bit per cycle after start
module serial_divider #(
  parameter int W = 14,
  parameter int QW = 9,
  parameter int DIVISOR = 58
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  dividend,
  output logic          done,
  output logic [QW-1:0] quotient
);
  localparam int RW = $clog2(DIVISOR);
  localparam int CW = $clog2(W + 1);
  logic [RW-1:0] r_rem;
  logic [W-1:0]  r_q;
  logic [CW-1:0] r_cnt;
  logic [RW:0]   w_sh;
  logic          w_ge;
  // remainder stays below DIVISOR, so the shifted value needs only one extra bit
  assign w_sh = {r_rem, r_q[W-1]};
  assign w_ge = w_sh >= (RW+1)'(DIVISOR);
  assign done = r_cnt == CW'(1);
  assign quotient = r_q[QW-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_q <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_rem <= '0;
      r_q <= dividend;
      r_cnt <= CW'(W);
    end else if (r_cnt != '0) begin
      r_rem <= RW'(w_ge ? w_sh - (RW+1)'(DIVISOR) : w_sh);
      r_q <= {r_q[W-2:0], w_ge};
      r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/distance_filter.sv
// distance_filter: validates echo times, converts to cm, averages 4 samples and drives a hysteretic near flag
module distance_filter #(
  parameter int TIMER_WIDTH = 14,
  parameter int US_PER_CM = ultrasonic_pkg::US_PER_CM,
  parameter int MAX_VALID_US = 14999,
  parameter int NEAR_CM = ultrasonic_pkg::NEAR_CM,
  parameter int HYST_CM = ultrasonic_pkg::HYST_CM,
  parameter int MISS_LIMIT = 3,
  localparam int DIST_W = $clog2((2**TIMER_WIDTH)/US_PER_CM + 1)
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [TIMER_WIDTH-1:0] recordTimer,
  input  logic                   busy,
  output logic [DIST_W-1:0]      distanceCm,
  output logic                   distanceValid,
  output logic                   near,
  output logic                   newSample,
  output logic                   sampleError
);
  import ultrasonic_pkg::*;
  localparam int SUM_W = DIST_W + 2;
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  state_t                 r_state, w_next;
  logic                   r_busy_d;
  logic [TIMER_WIDTH-1:0] r_sample;
  logic [MISS_W-1:0]      r_miss;
  logic [DIST_W-1:0]      r_hist [4];
  logic [1:0]             r_head;
  logic [2:0]             r_fill;
  logic [SUM_W-1:0]       r_sum;
  logic [DIST_W-1:0]      r_dist;
  logic                   r_valid, r_near, r_err;
  logic                   w_edge, w_invalid, w_start, w_done, w_drop, w_new;
  logic [DIST_W-1:0]      w_quot, w_avg;
  logic [MISS_W-1:0]      w_miss_next;
  logic [2:0]             w_fill_next;
  logic [SUM_W-1:0]       w_sum_next;
  assign w_edge = r_busy_d & ~busy;
  assign w_invalid = r_sample == '0 || r_sample > TIMER_WIDTH'(MAX_VALID_US);
  assign w_miss_next = r_miss == MISS_W'(MISS_LIMIT) ? r_miss : r_miss + 1'b1;
  assign w_drop = w_invalid && w_miss_next == MISS_W'(MISS_LIMIT);
  assign w_fill_next = r_fill == 3'd4 ? r_fill : r_fill + 3'd1;
  // oldest slot reads zero until the history is full, so the running sum never needs a special case
  assign w_sum_next = r_sum + {2'b00, w_quot} - {2'b00, r_hist[r_head]};
  assign w_avg = w_sum_next[SUM_W-1:2];
  serial_divider #(.W(TIMER_WIDTH), .QW(DIST_W), .DIVISOR(US_PER_CM)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .start(w_start),
    .dividend(r_sample),
    .done(w_done),
    .quotient(w_quot)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_edge ? S_CHECK : S_IDLE;
      S_CHECK:  w_next = w_invalid ? S_IDLE : S_DIVIDE;
      S_DIVIDE: w_next = w_done ? S_ACCUM : S_DIVIDE;
      S_ACCUM:  w_next = S_OUTPUT;
      default:  w_next = S_IDLE;
    endcase
  end
  always_comb begin
    w_start = r_state == S_CHECK && !w_invalid;
    w_new = r_state == S_OUTPUT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_d <= 1'b0;
      r_sample <= '0;
      r_miss <= '0;
      for (int i = 0; i < 4; i++) r_hist[i] <= '0;
      r_head <= '0;
      r_fill <= '0;
      r_sum <= '0;
      r_dist <= '0;
      r_valid <= 1'b0;
      r_near <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_busy_d <= busy;
      r_err <= r_state == S_CHECK && w_invalid;
      if (r_state == S_IDLE && w_edge) r_sample <= recordTimer;
      if (r_state == S_CHECK) begin
        r_miss <= w_invalid ? w_miss_next : '0;
        if (w_drop) begin
          for (int i = 0; i < 4; i++) r_hist[i] <= '0;
          r_head <= '0;
          r_fill <= '0;
          r_sum <= '0;
          r_valid <= 1'b0;
          r_near <= 1'b0;
        end
      end
      if (r_state == S_ACCUM) begin
        r_hist[r_head] <= w_quot;
        r_head <= r_head + 1'b1;
        r_fill <= w_fill_next;
        r_sum <= w_sum_next;
        r_dist <= w_avg;
        r_valid <= w_fill_next == 3'd4;
        if (w_fill_next == 3'd4)
          r_near <= w_avg <= DIST_W'(NEAR_CM) ? 1'b1 :
                    w_avg > DIST_W'(NEAR_CM + HYST_CM) ? 1'b0 : r_near;
      end
    end
  end
  assign distanceCm = r_dist;
  assign distanceValid = r_valid;
  assign near = r_near;
  assign newSample = w_new;
  assign sampleError = r_err;
endmodule

// File: tb/tb_distance_filter.sv
// tb_distance_filter: directed and random echo measurements checked against a queue-based averaging model
module tb_distance_filter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] recordTimer = '0;
  logic        busy = 1'b0;
  logic [8:0]  distanceCm;
  logic        distanceValid, near, newSample, sampleError;
  int total = 0;
  int bad = 0;
  int q[$];
  int miss = 0;
  int m_dist = 0;
  bit m_valid = 0;
  bit m_near = 0;

  distance_filter dut (
    .clk(clk),
    .rst_n(rst_n),
    .recordTimer(recordTimer),
    .busy(busy),
    .distanceCm(distanceCm),
    .distanceValid(distanceValid),
    .near(near),
    .newSample(newSample),
    .sampleError(sampleError)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    miss = 0;
    m_dist = 0;
    m_valid = 0;
    m_near = 0;
  endtask

  task automatic model_step(input int v);
    int s;
    if (v == 0 || v > 14999) begin
      if (miss < 3) miss++;
      if (miss == 3) begin
        q.delete();
        m_valid = 0;
        m_near = 0;
      end
    end else begin
      miss = 0;
      q.push_back(v / 58);
      if (q.size() > 4) void'(q.pop_front());
      s = 0;
      foreach (q[i]) s += q[i];
      m_dist = s / 4;
      m_valid = q.size() == 4;
      if (m_valid) begin
        if (m_dist <= 50) m_near = 1;
        else if (m_dist > 55) m_near = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_dist"}, int'(distanceCm), m_dist);
    check({tag, "_valid"}, int'(distanceValid), int'(m_valid));
    check({tag, "_near"}, int'(near), int'(m_near));
  endtask

  // dbl: raise and drop busy again while the first measurement is still being processed
  task automatic meas(input int v, input bit dbl);
    int ns_at, er_at, ns_cnt, er_cnt;
    bit ok;
    @(negedge clk);
    recordTimer = 14'(v);
    busy = 1'b1;
    repeat (2) @(negedge clk);
    busy = 1'b0;
    ns_at = -1; er_at = -1; ns_cnt = 0; er_cnt = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (dbl && i == 3) begin recordTimer = 14'd3248; busy = 1'b1; end
      if (dbl && i == 5) busy = 1'b0;
      if (newSample) begin ns_cnt++; if (ns_at < 0) ns_at = i; end
      if (sampleError) begin er_cnt++; if (er_at < 0) er_at = i; end
    end
    if (dbl) repeat (20) begin
      @(negedge clk);
      if (newSample) ns_cnt++;
    end
    ok = !(v == 0 || v > 14999);
    model_step(v);
    check("ns_count", ns_cnt, ok ? 1 : 0);
    check("err_count", er_cnt, ok ? 0 : 1);
    if (ok) check("ns_latency", ns_at, 17);
    else check("err_latency", er_at, 2);
    check_outputs(ok ? "valid" : "invalid");
  endtask

  initial begin
    int n, r, v;
    model_reset();
    #1;
    check("rst_dist", int'(distanceCm), 0);
    check("rst_valid", int'(distanceValid), 0);
    check("rst_near", int'(near), 0);
    check("rst_ns", int'(newSample), 0);
    check("rst_err", int'(sampleError), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (newSample || sampleError) n++;
    end
    check("idle_low_busy", n, 0);

    for (int i = 0; i < 4; i++) meas(2900, 0);
    check("lock_dist50", int'(distanceCm), 50);
    check("lock_near", int'(near), 1);
    for (int i = 0; i < 4; i++) meas(3190, 0);
    check("hyst_hold", int'(near), 1);
    for (int i = 0; i < 4; i++) meas(3248, 0);
    check("hyst_clear", int'(near), 0);

    for (int i = 0; i < 4; i++) meas(2900, 0);
    meas(0, 0);
    meas(15000, 0);
    check("two_miss_valid", int'(distanceValid), 1);
    for (int i = 0; i < 2; i++) meas(2957, 0);
    meas(0, 0);
    meas(16000, 0);
    meas(15000, 0);
    check("drop_valid", int'(distanceValid), 0);
    check("drop_near", int'(near), 0);
    meas(2900, 0);
    check("refill_dist", int'(distanceCm), 12);

    meas(2900, 1);

    @(negedge clk);
    recordTimer = 14'd3190;
    busy = 1'b1;
    repeat (2) @(negedge clk);
    busy = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("abort_dist", int'(distanceCm), 0);
    check("abort_valid", int'(distanceValid), 0);
    check("abort_near", int'(near), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (newSample) n++;
    end
    check("abort_no_ns", n, 0);
    meas(2900, 0);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      v = r == 0 ? 0 : r == 1 ? $urandom_range(15000, 16383) :
          r < 7 ? $urandom_range(2600, 3500) : $urandom_range(1, 14999);
      meas(v, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
